// File: rtl/oven_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oven_pkg
//  Purpose  : Shared types, cook-time constants and the selection decoder
//             used by the oven countdown engine.
//  Contents : timer_state_t  - countdown FSM states
//             T_S30/T_S60/T_S120 - selectable cook times in seconds
//             sel_to_secs()  - one-hot select to seconds (0 when invalid)
//  Revision : 1.0 - initial release
// ============================================================================
package oven_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } timer_state_t;

   localparam int unsigned SECS_W = 8;
   localparam logic [SECS_W-1:0] T_S30  = 8'd30;
   localparam logic [SECS_W-1:0] T_S60  = 8'd60;
   localparam logic [SECS_W-1:0] T_S120 = 8'd120;

   // Exactly one select must be set; anything else decodes to 0, which the
   // caller treats as an invalid load.
   function automatic logic [SECS_W-1:0] sel_to_secs(input logic s30,
                                                     input logic s60,
                                                     input logic s120);
      logic [SECS_W-1:0] secs;
      case ({s30, s60, s120})
         3'b100:  secs = T_S30;
         3'b010:  secs = T_S60;
         3'b001:  secs = T_S120;
         default: secs = '0;
      endcase
      return secs;
   endfunction

endpackage
`default_nettype wire

// File: rtl/oven_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : oven_prescaler
//  Purpose  : Divides clk down to a one-second cadence for the countdown.
//  Ports    : clk   - system clock
//             reset - asynchronous active-low reset
//             en    - advance the counter this cycle (holds when low)
//             clr   - synchronous clear to 0 (wins over en)
//             tick  - counter sits at its terminal count; the wrap and the
//                     one-second event happen on the next enabled edge
//  Revision : 1.0 - initial release
// ============================================================================
module oven_prescaler #(
   parameter int TICKS_PER_SEC = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
      end
   end

   // Terminal-count indicator is independent of en so the parent can use it
   // to decide en without a combinational loop.
   assign tick = (cnt == TERM);

endmodule
`default_nettype wire

// File: rtl/oven_timer.sv
`default_nettype none
// ============================================================================
//  Module   : oven_timer
//  Purpose  : Cook-time countdown engine: latches 30/60/120 s, counts down
//             once per second with pause/resume/abort, pulses timeout.
//  Ports    : clk, reset (async active-low)
//             s30/s60/s120, time_set - cook-time selection and load
//             start_count/stop_count - run/resume and pause levels
//             clear       - synchronous abort to IDLE
//             timeout     - one-cycle pulse on expiry
//             running/paused - state indicators
//             remaining   - seconds left
//             sec_tick    - one-cycle pulse on each decrement
//             sel_err     - one-cycle pulse on an invalid load in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module oven_timer
   import oven_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s30,
   input  logic             s60,
   input  logic             s120,
   input  logic             time_set,
   input  logic             start_count,
   input  logic             stop_count,
   input  logic             clear,
   output logic             timeout,
   output logic             running,
   output logic             paused,
   output logic [CNT_W-1:0] remaining,
   output logic             sec_tick,
   output logic             sel_err
);

   timer_state_t      state;
   logic              at_term;
   logic              pre_en;
   logic              pre_clr;
   logic              expire;
   logic [SECS_W-1:0] load_secs;

   assign load_secs = sel_to_secs(s30, s60, s120);

   // Expiry outranks stop_count, so the prescaler must still wrap on the
   // final second even if a pause is requested in that same cycle.
   assign expire  = (state == RUN) && at_term && (remaining == CNT_W'(1));
   assign pre_en  = (state == RUN) && (!stop_count || expire);
   // Holding the prescaler at 0 outside RUN/PAUSE guarantees a full first
   // second after every RUN entry from IDLE.
   assign pre_clr = clear || (state == IDLE) || (state == DONE);

   oven_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk  (clk),
      .reset(reset),
      .en   (pre_en),
      .clr  (pre_clr),
      .tick (at_term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         remaining <= '0;
         timeout   <= 1'b0;
         running   <= 1'b0;
         paused    <= 1'b0;
         sec_tick  <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         timeout  <= 1'b0;
         sec_tick <= 1'b0;
         sel_err  <= 1'b0;
         if (clear) begin
            state     <= IDLE;
            remaining <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  // A load in the same cycle as start wins; RUN follows on a
                  // later cycle once remaining is non-zero.
                  if (time_set) begin
                     if (load_secs != '0) remaining <= CNT_W'(load_secs);
                     else                 sel_err   <= 1'b1;
                  end else if (start_count && (remaining != '0)) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (expire) begin
                     state     <= DONE;
                     remaining <= '0;
                     timeout   <= 1'b1;
                     sec_tick  <= 1'b1;
                     running   <= 1'b0;
                  end else if (stop_count) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                     paused  <= 1'b1;
                  end else if (at_term) begin
                     remaining <= remaining - CNT_W'(1);
                     sec_tick  <= 1'b1;
                  end
               end
               PAUSE: begin
                  if (start_count && !stop_count) begin
                     state   <= RUN;
                     running <= 1'b1;
                     paused  <= 1'b0;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oven_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oven_timer
//  Purpose  : Directed self-checking bench for oven_timer (TICKS_PER_SEC=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oven_timer;

   localparam int TPS = 4;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          s30, s60, s120, time_set;
   logic          start_count, stop_count, clear;
   logic          timeout, running, paused, sec_tick, sel_err;
   logic [CW-1:0] remaining;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   oven_timer #(
      .TICKS_PER_SEC(TPS),
      .CNT_W        (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s30        (s30),
      .s60        (s60),
      .s120       (s120),
      .time_set   (time_set),
      .start_count(start_count),
      .stop_count (stop_count),
      .clear      (clear),
      .timeout    (timeout),
      .running    (running),
      .paused     (paused),
      .remaining  (remaining),
      .sec_tick   (sec_tick),
      .sel_err    (sel_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Compare the whole output set: running, paused, remaining, timeout,
   // sec_tick, sel_err.
   task automatic chk_all(input string tag, input logic r, input logic p,
                          input int rem, input logic to, input logic st,
                          input logic se);
      chk({tag, ".running"},   32'(running),   32'(r));
      chk({tag, ".paused"},    32'(paused),    32'(p));
      chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
      chk({tag, ".timeout"},   32'(timeout),   32'(to));
      chk({tag, ".sec_tick"},  32'(sec_tick),  32'(st));
      chk({tag, ".sel_err"},   32'(sel_err),   32'(se));
   endtask

   // Advance n rising edges; sample/drive 1 time unit after each edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic a, input logic b, input logic c);
      s30 = a; s60 = b; s120 = c; time_set = 1'b1;
      step(1);
      s30 = 1'b0; s60 = 1'b0; s120 = 1'b0; time_set = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      s30 = 0; s60 = 0; s120 = 0; time_set = 0;
      start_count = 0; stop_count = 0; clear = 0;
      #1 reset = 1'b0;
      #1 chk_all("reset", 0, 0, 0, 0, 0, 0);
      step(2);
      reset = 1'b1;
      step(1);
      chk_all("post_reset", 0, 0, 0, 0, 0, 0);

      // ---- invalid selections: two selects, then none ----
      load(1, 1, 0);
      chk_all("sel2_err", 0, 0, 0, 0, 0, 1);
      step(1);
      chk_all("sel2_after", 0, 0, 0, 0, 0, 0);
      load(0, 0, 0);
      chk_all("sel0_err", 0, 0, 0, 0, 0, 1);
      start_count = 1'b1;
      step(3);
      chk_all("start_ignored", 0, 0, 0, 0, 0, 0);
      start_count = 1'b0;

      // ---- s30 full countdown with held start ----
      load(1, 0, 0);
      chk_all("s30_load", 0, 0, 30, 0, 0, 0);
      start_count = 1'b1;
      step(1);
      chk_all("s30_run_entry", 1, 0, 30, 0, 0, 0);
      for (int k = 1; k <= 120; k++) begin
         step(1);
         chk("s30_rem",  32'(remaining), 32'(30 - k / 4));
         chk("s30_tick", 32'(sec_tick),  32'(k % 4 == 0));
         chk("s30_to",   32'(timeout),   32'(k == 120));
         chk("s30_run",  32'(running),   32'(k < 120));
      end
      step(1);
      chk_all("s30_idle", 0, 0, 0, 0, 0, 0);
      step(4);
      chk_all("s30_no_restart", 0, 0, 0, 0, 0, 0);
      start_count = 1'b0;

      // ---- s60 with pause (start and stop both high) ----
      load(0, 1, 0);
      start_count = 1'b1;
      step(1);
      chk_all("s60_entry", 1, 0, 60, 0, 0, 0);
      step(40);
      chk_all("s60_10ticks", 1, 0, 50, 0, 1, 0);
      step(2);
      stop_count = 1'b1;
      for (int k = 0; k < 17; k++) begin
         step(1);
         chk_all("s60_paused", 0, 1, 50, 0, 0, 0);
      end
      stop_count = 1'b0;
      step(1);
      chk_all("s60_resume", 1, 0, 50, 0, 0, 0);
      step(1);
      chk_all("s60_residual", 1, 0, 50, 0, 0, 0);
      step(1);
      chk_all("s60_tick_after_resume", 1, 0, 49, 0, 1, 0);
      step(195);
      chk_all("s60_last_sec", 1, 0, 1, 0, 0, 0);
      step(1);
      chk_all("s60_timeout", 0, 0, 0, 1, 1, 0);
      step(1);
      chk_all("s60_idle", 0, 0, 0, 0, 0, 0);
      start_count = 1'b0;

      // ---- stop on the expiry cycle still reaches DONE ----
      load(1, 0, 0);
      start_count = 1'b1;
      step(1);
      step(119);
      chk_all("exp_pre", 1, 0, 1, 0, 0, 0);
      stop_count = 1'b1;
      step(1);
      chk_all("exp_with_stop", 0, 0, 0, 1, 1, 0);
      step(1);
      chk_all("exp_stop_idle", 0, 0, 0, 0, 0, 0);
      stop_count = 1'b0;
      start_count = 1'b0;

      // ---- s120 with ignored time_set and clear abort ----
      load(0, 0, 1);
      start_count = 1'b1;
      step(1);
      step(20);
      chk_all("s120_5ticks", 1, 0, 115, 0, 1, 0);
      s30 = 1'b1; s60 = 1'b1; time_set = 1'b1;
      step(1);
      chk_all("s120_tset_ignored", 1, 0, 115, 0, 0, 0);
      s30 = 1'b0; s60 = 1'b0; time_set = 1'b0;
      step(1);
      clear = 1'b1;
      step(1);
      chk_all("clear", 0, 0, 0, 0, 0, 0);
      clear = 1'b0;
      start_count = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step(1);
         chk("clear_no_to", 32'(timeout), 32'(0));
      end

      // ---- rerun after clear: full first second, then async reset ----
      load(1, 0, 0);
      start_count = 1'b1;
      step(1);
      step(3);
      chk_all("rerun_pre_tick", 1, 0, 30, 0, 0, 0);
      step(1);
      chk_all("rerun_first_tick", 1, 0, 29, 0, 1, 0);
      step(2);
      #3 reset = 1'b0;
      #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0);
      step(1);
      reset = 1'b1;
      step(5);
      chk_all("after_reset_idle", 0, 0, 0, 0, 0, 0);
      start_count = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oven_timer.md
Name: oven_timer

Overview:
Cook-time countdown engine sequenced by ctrl_oven through its start_count/stop_count outputs. It returns the timeout input that ctrl_oven consumes.
- Latches the selected cook time (30/60/120 s).
- Generates a one-second tick from clk with an internal prescaler.
- Counts the loaded time down, supports pause/resume and abort, and raises a single-cycle timeout on expiry.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per second tick (minimum 2; benches use 4).
CNT_W, 8, width of remaining-seconds counter (must hold 120).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous reset, active-low (reset==0 resets), release synchronous to clk
s30  in  1  select 30 s
s60  in  1  select 60 s
s120  in  1  select 120 s
time_set  in  1  load strobe/level for the selection
start_count  in  1  level, from ctrl_oven: run/resume
stop_count  in  1  level, from ctrl_oven: pause
clear  in  1  synchronous abort to IDLE
timeout  out  1  one-cycle pulse on expiry
running  out  1  high in RUN
paused  out  1  high in PAUSE
remaining  out  CNT_W  seconds left
sec_tick  out  1  one-cycle pulse at each decrement
sel_err  out  1  one-cycle pulse on an invalid load

Behaviour:
- Reset (reset==0): state=IDLE; remaining=0; prescaler=0.
  - All outputs are 0 immediately, without waiting for a clock edge.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- IDLE:
  - time_set=1 with exactly one of s30/s60/s120 set: remaining loads 30/60/120 at the next edge.
  - time_set=1 with zero or more than one select set: no load; sel_err pulses one cycle.
  - start_count=1 with remaining!=0: go to RUN at the next edge, prescaler cleared to 0.
  - start_count=1 with remaining==0: ignored.
  - If time_set and start_count are both high in the same cycle, the load takes effect first and RUN is entered one cycle later.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1. At the terminal count it wraps to 0, sec_tick pulses and remaining decrements.
  - Decrement from 1 to 0: go to DONE.
  - First decrement occurs TICKS_PER_SEC cycles after the RUN entry edge.
  - stop_count=1: go to PAUSE; prescaler and remaining hold.
- PAUSE:
  - Prescaler and remaining frozen.
  - start_count=1 and stop_count=0: resume RUN; prescaler continues from its held value, not cleared.
- DONE:
  - Lasts exactly one cycle; timeout=1 in that cycle, remaining=0; then IDLE.
  - A held start_count does not restart, because remaining==0; a new load is required.
- Priorities:
  - clear > expiry > stop_count > start_count.
  - An expiry tick in the same cycle as stop_count still goes to DONE and still produces timeout.
  - In RUN/PAUSE, stop_count and start_count both high: stop wins.
- clear=1 in any state: IDLE at the next edge; remaining=0; prescaler=0; timeout is not asserted.
- time_set during RUN/PAUSE/DONE is ignored; no sel_err is raised.
- Arithmetic:
  - remaining is unsigned, decrements only, never wraps below 0.
  - Load constants are zero-extended to CNT_W.
- Asynchronous reset mid-RUN/PAUSE aborts with no timeout.

Decomposition:
- Shared package oven_pkg:
  - timer_state_t enum {IDLE, RUN, PAUSE, DONE}.
  - Constants T_S30=30, T_S60=60, T_S120=120.
  - Function sel_to_secs (returns 0 for an invalid selection).
- Sub-module oven_prescaler:
  - Inputs: clk, reset, en, clr.
  - Output: tick.
  - Parameter: TICKS_PER_SEC.
  - Counter holds its value when en=0.

Test Plan:
1. TICKS_PER_SEC=4. Load s30; start_count=1 at cycle N:
   - running=1 at N+1.
   - sec_tick and decrement every 4 cycles (29, 28, ...).
   - remaining reaches 0 at the 120th cycle after entering RUN, with timeout=1 for exactly one cycle.
   - running=0 afterwards; a held start_count does not restart.
2. Load s60; run 10 ticks; stop_count=1 for 17 cycles:
   - paused=1; remaining holds 50; no sec_tick.
   - Release stop: the next tick arrives after the residual prescaler count.
   - timeout occurs 240 active RUN cycles after start.
3. time_set with s30=s60=1:
   - sel_err pulses once; remaining stays 0.
   - start_count is then ignored (running stays 0).
4. Load s120; run 5 ticks; clear=1:
   - IDLE next cycle; remaining=0.
   - timeout never asserts; prescaler restarts at 0 on the next run.
5. Assert reset=0 mid-RUN between clock edges:
   - running, remaining and timeout go to 0 before the next edge.
   - After release, the block stays in IDLE.
6. Force stop_count=1 on the cycle where remaining goes 1→0:
   - DONE is entered; timeout=1; no PAUSE.
   - Also check that start_count and stop_count both high in RUN gives PAUSE.
